// File: rtl/alight_pkg.sv
// Shared constants, beat flag type and helpers for the atmospheric light estimator.
package alight_pkg;

  localparam int unsigned DefDw    = 8;
  localparam int unsigned DefWin   = 3;
  localparam int unsigned MaxDw    = 32;
  localparam int unsigned IirRound = 2;

  typedef struct packed {
    logic valid;
    logic sof;
    logic eof;
  } beat_flags_t;

  function automatic logic [MaxDw-1:0] min2(input logic [MaxDw-1:0] a,
                                            input logic [MaxDw-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic int unsigned centre_idx(input int unsigned win);
    return (win * win) / 2;
  endfunction

endpackage

// File: rtl/win_min.sv
// Registered min-reduction over N packed samples of one channel, plus centre-sample capture.
module win_min
  import alight_pkg::*;
#(
  parameter int unsigned DW     = DefDw,
  parameter int unsigned N      = DefWin * DefWin,
  parameter int unsigned CtrIdx = N / 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            en_i,
  input  logic [N*DW-1:0] win_i,
  output logic [DW-1:0]   min_o,
  output logic [DW-1:0]   centre_o
);

  logic [DW-1:0] min_d, min_q;
  logic [DW-1:0] centre_d, centre_q;

  always_comb begin
    min_d = win_i[DW-1:0];
    for (int unsigned k = 1; k < N; k++) begin
      min_d = DW'(min2(MaxDw'(min_d), MaxDw'(win_i[k*DW +: DW])));
    end
    centre_d = win_i[CtrIdx*DW +: DW];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      min_q    <= '0;
      centre_q <= '0;
    end else if (en_i) begin
      min_q    <= min_d;
      centre_q <= centre_d;
    end
  end

  assign min_o    = min_q;
  assign centre_o = centre_q;

endmodule

// File: rtl/alight_est_frame.sv
// Frame-level atmospheric light estimator: dark channel per beat, brightest-dark capture, A at eof.
// Define ALIGHT_IIR_EN to smooth A across frames with a 3/4 : 1/4 rounded blend.
module alight_est_frame
  import alight_pkg::*;
#(
  parameter int unsigned DW  = DefDw,
  parameter int unsigned WIN = DefWin
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic                in_valid,
  input  logic                sof,
  input  logic                eof,
  input  logic [WIN*WIN*DW-1:0] win_r,
  input  logic [WIN*WIN*DW-1:0] win_g,
  input  logic [WIN*WIN*DW-1:0] win_b,
  output logic [DW-1:0]       dark_out,
  output logic                dark_valid,
  output logic [DW-1:0]       a_r,
  output logic [DW-1:0]       a_g,
  output logic [DW-1:0]       a_b,
  output logic                a_valid
);

  localparam int unsigned N      = WIN * WIN;
  localparam int unsigned CtrIdx = centre_idx(WIN);

  // Channel index 0 = R, 1 = G, 2 = B throughout.
  logic [2:0][N*DW-1:0] win_all;
  logic [2:0][DW-1:0]   mins, ctr1, ctr2_q;
  logic [2:0][DW-1:0]   cap_d, cap_q, a_d, a_q, pick;
  beat_flags_t          fl1_d, fl1_q, fl2_q;
  logic [DW-1:0]        dark_d, dark_q, max_d, max_q;
  logic                 av_d, av_q, take;
`ifdef ALIGHT_IIR_EN
  logic                 primed_d, primed_q;

  function automatic logic [DW-1:0] blend(input logic [DW-1:0] prev, input logic [DW-1:0] cap);
    logic [DW+1:0] p, s;
    p = {2'b00, prev};
    s = p + {p[DW:0], 1'b0} + {2'b00, cap} + (DW+2)'(IirRound);
    return DW'(s >> 2);
  endfunction
`endif

  assign win_all = {win_b, win_g, win_r};

  for (genvar c = 0; c < 3; c++) begin : g_ch
    win_min #(
      .DW    (DW),
      .N     (N),
      .CtrIdx(CtrIdx)
    ) u_win_min (
      .clk_i   (clock),
      .rst_i   (reset),
      .en_i    (enable),
      .win_i   (win_all[c]),
      .min_o   (mins[c]),
      .centre_o(ctr1[c])
    );
  end

  always_comb begin
    fl1_d  = '{valid: in_valid, sof: in_valid & sof, eof: in_valid & eof};
    dark_d = DW'(min2(MaxDw'(mins[0]), min2(MaxDw'(mins[1]), MaxDw'(mins[2]))));
  end

  // A sof beat always seeds; later beats win only on a strictly greater dark value.
  always_comb begin
    take  = fl2_q.valid && (fl2_q.sof || (dark_q > max_q));
    pick  = take ? ctr2_q : cap_q;
    max_d = max_q;
    cap_d = cap_q;
    a_d   = a_q;
    av_d  = 1'b0;
`ifdef ALIGHT_IIR_EN
    primed_d = primed_q;
`endif
    if (take) begin
      max_d = dark_q;
      cap_d = ctr2_q;
    end
    if (fl2_q.valid && fl2_q.eof) begin
      max_d = '0;
      cap_d = '0;
      av_d  = 1'b1;
`ifdef ALIGHT_IIR_EN
      for (int c = 0; c < 3; c++) begin
        a_d[c] = primed_q ? blend(a_q[c], pick[c]) : pick[c];
      end
      primed_d = 1'b1;
`else
      a_d = pick;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fl1_q    <= '0;
      fl2_q    <= '0;
      dark_q   <= '0;
      ctr2_q   <= '0;
      max_q    <= '0;
      cap_q    <= '0;
      a_q      <= '0;
      av_q     <= 1'b0;
`ifdef ALIGHT_IIR_EN
      primed_q <= 1'b0;
`endif
    end else if (enable) begin
      fl1_q    <= fl1_d;
      fl2_q    <= fl1_q;
      dark_q   <= dark_d;
      ctr2_q   <= ctr1;
      max_q    <= max_d;
      cap_q    <= cap_d;
      a_q      <= a_d;
      av_q     <= av_d;
`ifdef ALIGHT_IIR_EN
      primed_q <= primed_d;
`endif
    end
  end

  // A pulse held while frozen is shown once enable returns.
  assign dark_out   = dark_q;
  assign dark_valid = fl2_q.valid & enable;
  assign a_r        = a_q[0];
  assign a_g        = a_q[1];
  assign a_b        = a_q[2];
  assign a_valid    = av_q & enable;

endmodule

// File: tb/tb_alight_est_frame.sv
// Scoreboard bench for alight_est_frame: reference model pushes expectations, monitor pops.
module tb_alight_est_frame;

  localparam int DW = 8;
  localparam int WIN = 3;
  localparam int N = WIN * WIN;

  logic clock = 1'b0;
  logic reset, enable, in_valid, sof, eof;
  logic [N*DW-1:0] win_r, win_g, win_b;
  logic [DW-1:0] dark_out, a_r, a_g, a_b;
  logic dark_valid, a_valid;

  alight_est_frame #(.DW(DW), .WIN(WIN)) dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .in_valid  (in_valid),
    .sof       (sof),
    .eof       (eof),
    .win_r     (win_r),
    .win_g     (win_g),
    .win_b     (win_b),
    .dark_out  (dark_out),
    .dark_valid(dark_valid),
    .a_r       (a_r),
    .a_g       (a_g),
    .a_b       (a_b),
    .a_valid   (a_valid)
  );

  always #5 clock = ~clock;

  typedef struct { int val; int due; } dexp_t;
  typedef struct { int r; int g; int b; int due; } aexp_t;
  dexp_t dq[$];
  aexp_t aq[$];

  int n_cmp = 0, n_bad = 0;
  int ecnt = 0, wcnt = 0;
  int last_d = -1, last_a = -1, last_a_wall = 0;
  int best, cap_r, cap_g, cap_b, prev_r, prev_g, prev_b;
  bit primed;

  always @(posedge clock) begin
    wcnt++;
    if (enable && !reset) ecnt++;
  end

  function automatic void check(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  function automatic void model_reset();
    best = 0; cap_r = 0; cap_g = 0; cap_b = 0;
    prev_r = 0; prev_g = 0; prev_b = 0; primed = 0;
    dq.delete(); aq.delete();
    last_d = -1; last_a = -1;
  endfunction

  // Monitor: one look per enabled cycle, away from the clock edge.
  always begin
    @(negedge clock);
    #2;
    if (!enable) check("gated_outputs", int'({dark_valid, a_valid}), 0);
    if (!reset && dark_valid && ecnt != last_d) begin
      last_d = ecnt;
      if (dq.size() == 0) check("dark_unexpected", 1, 0);
      else begin
        dexp_t e;
        e = dq.pop_front();
        check("dark_value", int'(dark_out), e.val);
        check("dark_latency", ecnt, e.due);
      end
    end
    if (!reset && a_valid && ecnt != last_a) begin
      last_a = ecnt;
      last_a_wall = wcnt;
      if (aq.size() == 0) check("a_unexpected", 1, 0);
      else begin
        aexp_t e;
        e = aq.pop_front();
        check("a_r", int'(a_r), e.r);
        check("a_g", int'(a_g), e.g);
        check("a_b", int'(a_b), e.b);
        check("a_latency", ecnt, e.due);
      end
    end
  end

  // Called just after a negedge with enable high; beat is sampled on the next posedge.
  task automatic drive_beat(input bit s, input bit e, input logic [N*DW-1:0] r,
                            input logic [N*DW-1:0] g, input logic [N*DW-1:0] b);
    int dk, ar, ag, ab;
    in_valid = 1'b1; sof = s; eof = e;
    win_r = r; win_g = g; win_b = b;
    dk = 1 << DW;
    for (int k = 0; k < N; k++) begin
      if (int'(r[k*DW +: DW]) < dk) dk = int'(r[k*DW +: DW]);
      if (int'(g[k*DW +: DW]) < dk) dk = int'(g[k*DW +: DW]);
      if (int'(b[k*DW +: DW]) < dk) dk = int'(b[k*DW +: DW]);
    end
    dq.push_back('{val: dk, due: ecnt + 2});
    if (s || dk > best) begin
      best = dk;
      cap_r = int'(r[(N/2)*DW +: DW]);
      cap_g = int'(g[(N/2)*DW +: DW]);
      cap_b = int'(b[(N/2)*DW +: DW]);
    end
    if (e) begin
      ar = cap_r; ag = cap_g; ab = cap_b;
`ifdef ALIGHT_IIR_EN
      if (primed) begin
        ar = (3 * prev_r + cap_r + 2) / 4;
        ag = (3 * prev_g + cap_g + 2) / 4;
        ab = (3 * prev_b + cap_b + 2) / 4;
      end
      primed = 1;
`endif
      prev_r = ar; prev_g = ag; prev_b = ab;
      aq.push_back('{r: ar, g: ag, b: ab, due: ecnt + 3});
      best = 0; cap_r = 0; cap_g = 0; cap_b = 0;
    end
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  function automatic logic [N*DW-1:0] mk(int minv, int ctr, int off);
    logic [N*DW-1:0] w;
    int v;
    for (int k = 0; k < N; k++) begin
      v = (k == N / 2) ? ctr : (k == 7) ? minv : minv + 3 + k;
      w[k*DW +: DW] = DW'(v + off);
    end
    return w;
  endfunction

  task automatic beat3(input bit s, input bit e, input int minv, input int ctr);
    drive_beat(s, e, mk(minv, ctr, 0), mk(minv, ctr, 10), mk(minv, ctr, 20));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b0; sof = 1'($urandom); eof = 1'($urandom);
      @(negedge clock);
    end
  endtask

  task automatic freeze(input int n);
    enable = 1'b0;
    idle(n);
    enable = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b1; in_valid = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic drain();
    int i = 0;
    while ((dq.size() > 0 || aq.size() > 0) && i < 30) begin
      @(negedge clock);
      i++;
    end
    repeat (2) @(negedge clock);
    check("drain_empty", dq.size() + aq.size(), 0);
  endtask

  task automatic check_a(string name, int r, int g, int b);
    check({name, "_r"}, int'(a_r), r);
    check({name, "_g"}, int'(a_g), g);
    check({name, "_b"}, int'(a_b), b);
  endtask

  initial begin
    int t1[N] = '{191, 187, 194, 185, 205, 200, 195, 190, 186};
    logic [N*DW-1:0] r, g, b;
    int eof_w, nb, base, exp6;
    bit s;

    reset = 1'b1; enable = 1'b1; in_valid = 1'b0; sof = 1'b0; eof = 1'b0;
    win_r = '0; win_g = '0; win_b = '0;
    @(negedge clock);
    do_reset();
    check("rst_dark_out", int'(dark_out), 0);
    check("rst_dark_valid", int'(dark_valid), 0);
    check_a("rst_a", 0, 0, 0);
    check("rst_a_valid", int'(a_valid), 0);

    // Single-beat frame
    for (int k = 0; k < N; k++) begin
      r[k*DW +: DW] = DW'(t1[k]);
      g[k*DW +: DW] = DW'(t1[k] + 10);
      b[k*DW +: DW] = DW'(t1[k] + 20);
    end
    drive_beat(1, 1, r, g, b);
    drain();
    check_a("t1", 205, 215, 225);

    // Three beats, second wins
    do_reset();
    beat3(1, 0, 185, 201);
    beat3(0, 0, 198, 210);
    beat3(0, 1, 195, 220);
    drain();
    check_a("t2", 210, 220, 230);

    // Tie keeps earliest
    do_reset();
    beat3(1, 0, 198, 205);
    beat3(0, 1, 198, 215);
    drain();
    check_a("t3", 205, 215, 225);

    // Enable dropped mid-frame and while the pulse is pending
    do_reset();
    beat3(1, 0, 150, 160);
    freeze(2);
    beat3(0, 0, 170, 180);
    eof_w = wcnt;
    beat3(0, 1, 160, 190);
    freeze(2);
    drain();
    check_a("t4", 180, 190, 200);
    check("t4_a_wall_delay", last_a_wall - eof_w, 5);

    // Reset mid-frame discards it
    do_reset();
    beat3(1, 0, 220, 230);
    idle(1);
    do_reset();
    check("t5_dark_out", int'(dark_out), 0);
    check_a("t5_rst", 0, 0, 0);
    idle(5);
    beat3(1, 0, 100, 120);
    beat3(0, 1, 90, 140);
    drain();
    check_a("t5", 120, 130, 140);

    // Second frame after reset: raw vs smoothed
    do_reset();
    beat3(1, 1, 50, 200);
    idle(2);
    beat3(1, 1, 50, 100);
    drain();
`ifdef ALIGHT_IIR_EN
    exp6 = 175;
`else
    exp6 = 100;
`endif
    check("t6_a_r", int'(a_r), exp6);

    // Randomized frames with bubbles, freezes, missing sof and near-tie values
    for (int f = 0; f < 40; f++) begin
      nb = $urandom_range(1, 5);
      for (int bt = 0; bt < nb; bt++) begin
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        if ($urandom_range(0, 5) == 0) freeze($urandom_range(1, 3));
        s = (bt == 0) && ($urandom_range(0, 9) != 0);
        base = $urandom_range(0, 200);
        for (int k = 0; k < N; k++) begin
          r[k*DW +: DW] = DW'(base + $urandom_range(0, 40));
          g[k*DW +: DW] = DW'(base + $urandom_range(0, 40));
          b[k*DW +: DW] = DW'(base + $urandom_range(0, 40));
        end
        drive_beat(s, bt == nb - 1, r, g, b);
      end
      if (f % 10 == 9) begin
        drain();
        if (f == 19) do_reset();
      end
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
